pmem_arbiter: RTL and testbench

- Shares the single physical-memory port between the I-cache (IF stage, read-only) and the D-cache (MEM stage, fed by the EX/MEM pipeline register; read/write).
- Serves one line transaction at a time. A Moore FSM latches the granted request and drives pmem until pmem_resp, then returns the response to the winner.
- D-cache normally wins ties, because the older instruction is stalled in MEM. A starvation counter guarantees the I-cache forward progress.

---
 rtl/pmem_arbiter_pkg.sv | 13 +
 rtl/pmem_arbiter.sv | 123 ++++++++++++
 tb/tb_pmem_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_pkg.sv
// rtl/pmem_arbiter_pkg.sv - shared types for the physical-memory arbiter
package pmem_arbiter_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_pmem_line;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } pmem_arb_state_t;

endpackage

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - single-port pmem arbiter between I-cache and D-cache
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int LINE_W   = 128,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              icache_pmem_read,
    input  logic [15:0]       icache_pmem_address,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [15:0]       dcache_pmem_address,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [15:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [1:0]        arb_state
);

    localparam logic [7:0] WAIT_SAT = 8'(MAX_WAIT);

    pmem_arb_state_t   state, state_next;
    logic [7:0]        icache_wait;
    lc3b_word          lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic              lat_read, lat_write;
    logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
    logic              i_req, d_req, grant_i, grant_d;
    logic              i_done, d_done, serving;

    assign i_req = icache_pmem_read;
    assign d_req = dcache_pmem_read | dcache_pmem_write;

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            ARB_IDLE: begin
                // D-cache holds the older instruction, so it wins ties unless I is starving
                if (i_req && (!d_req || icache_wait == WAIT_SAT)) begin
                    grant_i    = 1'b1;
                    state_next = ARB_SERVE_I;
                end else if (d_req) begin
                    grant_d    = 1'b1;
                    state_next = ARB_SERVE_D;
                end
            end
            ARB_SERVE_I, ARB_SERVE_D: begin
                if (pmem_resp) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ARB_IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
        end else if (grant_i) begin
            lat_addr  <= icache_pmem_address;
            lat_wdata <= '0;
            lat_read  <= 1'b1;
            lat_write <= 1'b0;
        end else if (grant_d) begin
            lat_addr  <= dcache_pmem_address;
            lat_wdata <= dcache_pmem_wdata;
            lat_read  <= !dcache_pmem_write;
            lat_write <= dcache_pmem_write;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            icache_wait <= '0;
        else if (grant_i)
            icache_wait <= '0;
        else if (i_req && state != ARB_SERVE_I && icache_wait != WAIT_SAT)
            icache_wait <= icache_wait + 8'd1;
    end

    assign serving = (state != ARB_IDLE);
    assign i_done  = (state == ARB_SERVE_I) && pmem_resp;
    assign d_done  = (state == ARB_SERVE_D) && pmem_resp;

    // Each side keeps showing its last delivered line between transactions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (i_done) i_rdata_q <= pmem_rdata;
            if (d_done) d_rdata_q <= pmem_rdata;
        end
    end

    assign pmem_read         = serving && lat_read;
    assign pmem_write        = serving && lat_write;
    assign pmem_address      = lat_addr;
    assign pmem_wdata        = lat_wdata;
    assign icache_pmem_resp  = i_done;
    assign dcache_pmem_resp  = d_done;
    assign icache_pmem_rdata = i_done ? pmem_rdata : i_rdata_q;
    assign dcache_pmem_rdata = d_done ? pmem_rdata : d_rdata_q;
    assign arb_state         = state;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - self-checking bench for pmem_arbiter
module tb_pmem_arbiter;

    localparam int LINE_W   = 128;
    localparam int MAX_WAIT = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              icache_pmem_read;
    logic [15:0]       icache_pmem_address;
    logic [LINE_W-1:0] icache_pmem_rdata;
    logic              icache_pmem_resp;
    logic              dcache_pmem_read;
    logic              dcache_pmem_write;
    logic [15:0]       dcache_pmem_address;
    logic [LINE_W-1:0] dcache_pmem_wdata;
    logic [LINE_W-1:0] dcache_pmem_rdata;
    logic              dcache_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [15:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [1:0]        arb_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmem_arbiter #(.LINE_W(LINE_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .icache_pmem_read(icache_pmem_read), .icache_pmem_address(icache_pmem_address),
        .icache_pmem_rdata(icache_pmem_rdata), .icache_pmem_resp(icache_pmem_resp),
        .dcache_pmem_read(dcache_pmem_read), .dcache_pmem_write(dcache_pmem_write),
        .dcache_pmem_address(dcache_pmem_address), .dcache_pmem_wdata(dcache_pmem_wdata),
        .dcache_pmem_rdata(dcache_pmem_rdata), .dcache_pmem_resp(dcache_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .arb_state(arb_state)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        icache_pmem_read    = 1'b0;
        icache_pmem_address = '0;
        dcache_pmem_read    = 1'b0;
        dcache_pmem_write   = 1'b0;
        dcache_pmem_address = '0;
        dcache_pmem_wdata   = '0;
        pmem_rdata          = '0;
        pmem_resp           = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000",
                               {pmem_read, pmem_write, icache_pmem_resp, dcache_pmem_resp});
        end
        checks++;
        if (arb_state !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", arb_state);
        end
        checks++;
        if ({pmem_address, pmem_wdata, icache_pmem_rdata, dcache_pmem_rdata} !== '0) begin
            errors++; $display("FAIL reset_data: addr %h wdata %h expected all zero", pmem_address, pmem_wdata);
        end
    endtask

    task automatic test_lone_i();
        logic [LINE_W-1:0] a5 = {16{8'hA5}};
        do_reset();
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 16'h1230;
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++; $display("FAIL lone_i_cycle0: pmem_read %b expected 0", pmem_read);
        end
        for (int c = 1; c <= 5; c++) begin
            cyc();
            pmem_resp  = (c == 5);
            pmem_rdata = (c == 5) ? a5 : '0;
            #1;
            checks++;
            if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1230) begin
                errors++; $display("FAIL lone_i_strobe c%0d: rd %b wr %b addr %h expected 1 0 1230",
                                   c, pmem_read, pmem_write, pmem_address);
            end
            checks++;
            if (icache_pmem_resp !== (c == 5) || dcache_pmem_resp !== 1'b0) begin
                errors++; $display("FAIL lone_i_resp c%0d: i %b d %b expected %b 0",
                                   c, icache_pmem_resp, dcache_pmem_resp, c == 5);
            end
        end
        checks++;
        if (icache_pmem_rdata !== a5) begin
            errors++; $display("FAIL lone_i_rdata: got %h expected %h", icache_pmem_rdata, a5);
        end
        cyc();
        icache_pmem_read = 1'b0;
        pmem_resp        = 1'b0;
        pmem_rdata       = '0;
        #1;
        checks++;
        if (arb_state !== 2'd0 || pmem_read !== 1'b0 || icache_pmem_resp !== 1'b0) begin
            errors++; $display("FAIL lone_i_idle: state %0d rd %b resp %b expected 0 0 0",
                               arb_state, pmem_read, icache_pmem_resp);
        end
        checks++;
        if (icache_pmem_rdata !== a5) begin
            errors++; $display("FAIL lone_i_hold: got %h expected %h", icache_pmem_rdata, a5);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        dcache_pmem_write   = 1'b1;
        dcache_pmem_address = 16'h4000;
        dcache_pmem_wdata   = 128'h1;
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 16'h0010;
        cyc();
        #1;
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h4000 || pmem_wdata !== 128'h1) begin
            errors++; $display("FAIL sim_d_first: wr %b rd %b addr %h wdata %h expected 1 0 4000 1",
                               pmem_write, pmem_read, pmem_address, pmem_wdata);
        end
        cyc();
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0) begin
            errors++; $display("FAIL sim_d_resp: d %b i %b expected 1 0", dcache_pmem_resp, icache_pmem_resp);
        end
        cyc();
        pmem_resp         = 1'b0;
        dcache_pmem_write = 1'b0;
        #1;
        checks++;
        if (arb_state !== 2'd0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            errors++; $display("FAIL sim_gap: state %0d rd %b wr %b expected 0 0 0", arb_state, pmem_read, pmem_write);
        end
        cyc();
        #1;
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h0010 || arb_state !== 2'd1) begin
            errors++; $display("FAIL sim_i_second: rd %b addr %h state %0d expected 1 0010 1",
                               pmem_read, pmem_address, arb_state);
        end
        cyc();
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (icache_pmem_resp !== 1'b1) begin
            errors++; $display("FAIL sim_i_resp: got %b expected 1", icache_pmem_resp);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_starvation();
        do_reset();
        dcache_pmem_read    = 1'b1;
        dcache_pmem_address = 16'h4000;
        icache_pmem_read    = 1'b1;
        icache_pmem_address = 16'h0200;
        // zero-latency D services: wait is 2 after the first, saturated after the second
        for (int t = 0; t < 3; t++) begin
            cyc();
            pmem_resp  = 1'b1;
            pmem_rdata = LINE_W'(t + 7);
            #1;
            checks++;
            if (pmem_address !== ((t < 2) ? 16'h4000 : 16'h0200)) begin
                errors++; $display("FAIL starve_addr t%0d: got %h expected %h",
                                   t, pmem_address, (t < 2) ? 16'h4000 : 16'h0200);
            end
            checks++;
            if (dcache_pmem_resp !== (t < 2) || icache_pmem_resp !== (t == 2)) begin
                errors++; $display("FAIL starve_winner t%0d: d %b i %b expected %b %b",
                                   t, dcache_pmem_resp, icache_pmem_resp, t < 2, t == 2);
            end
            cyc();
            pmem_resp = 1'b0;
            if (t == 2) icache_pmem_read = 1'b0;
            #1;
            checks++;
            if (arb_state !== 2'd0) begin
                errors++; $display("FAIL starve_idle t%0d: state %0d expected 0", t, arb_state);
            end
        end
        idle_inputs();
    endtask

    task automatic test_addr_stability();
        do_reset();
        dcache_pmem_read    = 1'b1;
        dcache_pmem_address = 16'h4000;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 2) dcache_pmem_address = 16'h5000;
            pmem_resp = (c == 4);
            #1;
            checks++;
            if (pmem_address !== 16'h4000 || pmem_read !== 1'b1) begin
                errors++; $display("FAIL addr_stable c%0d: addr %h rd %b expected 4000 1", c, pmem_address, pmem_read);
            end
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_rw_both();
        logic [LINE_W-1:0] wd;
        int nresp = 0;
        do_reset();
        wd = {$urandom(), $urandom(), $urandom(), $urandom()};
        dcache_pmem_read    = 1'b1;
        dcache_pmem_write   = 1'b1;
        dcache_pmem_address = 16'h7770;
        dcache_pmem_wdata   = wd;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            pmem_resp = (c == 2);
            if (c == 3) begin
                dcache_pmem_read  = 1'b0;
                dcache_pmem_write = 1'b0;
            end
            #1;
            if (dcache_pmem_resp === 1'b1) nresp++;
            checks++;
            if (pmem_read !== 1'b0 || pmem_write !== (c <= 2)) begin
                errors++; $display("FAIL rw_both_strobe c%0d: rd %b wr %b expected 0 %b", c, pmem_read, pmem_write, c <= 2);
            end
            if (c == 1) begin
                checks++;
                if (pmem_wdata !== wd) begin
                    errors++; $display("FAIL rw_both_wdata: got %h expected %h", pmem_wdata, wd);
                end
            end
        end
        checks++;
        if (nresp != 1) begin
            errors++; $display("FAIL rw_both_resp_count: got %0d expected 1", nresp);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        dcache_pmem_read    = 1'b1;
        dcache_pmem_address = 16'h3000;
        cyc();
        #1;
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++; $display("FAIL rmid_inflight: rd %b expected 1", pmem_read);
        end
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || arb_state !== 2'd0 || pmem_address !== 16'h0) begin
            errors++; $display("FAIL rmid_async: rd %b wr %b state %0d addr %h expected 0 0 0 0000",
                               pmem_read, pmem_write, arb_state, pmem_address);
        end
        cyc();
        reset_n          = 1'b1;
        dcache_pmem_read = 1'b0;
        cyc();
        pmem_resp  = 1'b1;
        pmem_rdata = {4{32'hDEADBEEF}};
        #1;
        checks++;
        if (dcache_pmem_resp !== 1'b0 || icache_pmem_resp !== 1'b0 || dcache_pmem_rdata !== '0) begin
            errors++; $display("FAIL rmid_stray: d %b i %b drdata %h expected 0 0 0",
                               dcache_pmem_resp, icache_pmem_resp, dcache_pmem_rdata);
        end
        cyc();
        pmem_resp = 1'b0;
        #1;
        checks++;
        if (arb_state !== 2'd0 || pmem_read !== 1'b0) begin
            errors++; $display("FAIL rmid_after: state %0d rd %b expected 0 0", arb_state, pmem_read);
        end
        idle_inputs();
    endtask

    // Reference: who is served, what was captured at grant, and how long I has gone ungranted
    task automatic test_random();
        int ms = 0, mw = 0, mem_left = 0, grant, sel;
        bit mem_active = 0, i_pend = 0, d_pend = 0, i_done, d_done, i_req, d_req;
        logic [15:0] m_addr = '0;
        logic [LINE_W-1:0] m_wdata = '0, exp_i = '0, exp_d = '0;
        bit m_wr = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            cyc();
            pmem_resp  = 1'b0;
            pmem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (ms != 0) begin
                if (!mem_active) begin
                    mem_active = 1;
                    mem_left   = $urandom_range(0, 3);
                end
                if (mem_left == 0) begin
                    pmem_resp  = 1'b1;
                    mem_active = 0;
                end else mem_left--;
            end else pmem_resp = ($urandom_range(0, 7) == 0);
            if (!i_pend && $urandom_range(0, 2) == 0) i_pend = 1;
            if (!d_pend && $urandom_range(0, 2) == 0) d_pend = 1;
            sel = $urandom_range(0, 3);
            icache_pmem_read    = i_pend;
            icache_pmem_address = 16'($urandom());
            dcache_pmem_read    = d_pend && (sel != 1);
            dcache_pmem_write   = d_pend && (sel == 1 || sel == 2);
            dcache_pmem_address = 16'($urandom());
            dcache_pmem_wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1;
            i_done = (ms == 1) && pmem_resp;
            d_done = (ms == 2) && pmem_resp;
            if (i_done) exp_i = pmem_rdata;
            if (d_done) exp_d = pmem_rdata;
            checks++;
            if (pmem_read !== (ms != 0 && !m_wr) || pmem_write !== (ms != 0 && m_wr) || arb_state !== 2'(ms)) begin
                errors++; $display("FAIL rand_ctrl c%0d: rd %b wr %b state %0d expected %b %b %0d",
                                   c, pmem_read, pmem_write, arb_state, ms != 0 && !m_wr, ms != 0 && m_wr, ms);
            end
            if (ms != 0) begin
                checks++;
                if (pmem_address !== m_addr || (m_wr && pmem_wdata !== m_wdata)) begin
                    errors++; $display("FAIL rand_addr c%0d: addr %h wdata %h expected %h %h",
                                       c, pmem_address, pmem_wdata, m_addr, m_wdata);
                end
            end
            checks++;
            if (icache_pmem_resp !== i_done || dcache_pmem_resp !== d_done) begin
                errors++; $display("FAIL rand_resp c%0d: i %b d %b expected %b %b",
                                   c, icache_pmem_resp, dcache_pmem_resp, i_done, d_done);
            end
            checks++;
            if (icache_pmem_rdata !== exp_i || dcache_pmem_rdata !== exp_d) begin
                errors++; $display("FAIL rand_rdata c%0d: i %h d %h expected %h %h",
                                   c, icache_pmem_rdata, dcache_pmem_rdata, exp_i, exp_d);
            end
            i_req = icache_pmem_read;
            d_req = dcache_pmem_read || dcache_pmem_write;
            grant = 0;
            if (ms == 0) begin
                if (i_req && (!d_req || mw == MAX_WAIT)) grant = 1;
                else if (d_req) grant = 2;
            end
            if (grant == 1) mw = 0;
            else if (i_req && ms != 1 && mw < MAX_WAIT) mw++;
            if (grant != 0) begin
                ms      = grant;
                m_addr  = (grant == 1) ? icache_pmem_address : dcache_pmem_address;
                m_wr    = (grant == 2) && dcache_pmem_write;
                m_wdata = dcache_pmem_wdata;
            end else if (ms != 0 && pmem_resp) ms = 0;
            if (i_done) i_pend = 0;
            if (d_done) d_pend = 0;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_lone_i();
        test_simultaneous();
        test_starvation();
        test_addr_stability();
        test_rw_both();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
